// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of an asynchronous clock-like input in clk_in cycles.
// Define DUTY_CHECK_EN to add the duty_ok output (|high_cnt - low_cnt| <= 1).
module clk_period_meter #(
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1024,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             en,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             locked,
`ifdef DUTY_CHECK_EN
   output logic             duty_ok,
`endif
   output logic             err_timeout
);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LOCK_V    = 4'(LOCK_CNT);

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, hi_tmp_q, hi_tmp_d;
   logic [CNT_W-1:0] high_q, high_d, low_q, low_d, period_q, period_d;
   logic             valid_q, valid_d, locked_q, locked_d, err_q, err_d;
   logic [3:0]       match_q, match_d;
   logic             rise_det, fall_det, timeout_hit;
   logic [CNT_W-1:0] new_period;
`ifdef DUTY_CHECK_EN
   logic             duty_q, duty_d;
   logic [CNT_W-1:0] duty_diff;
`endif

   assign rise_det    = sync2_q & ~dly_q;
   assign fall_det    = ~sync2_q & dly_q;
   assign timeout_hit = (cnt_q == TIMEOUT_V);
   assign new_period  = hi_tmp_q + cnt_q;
`ifdef DUTY_CHECK_EN
   assign duty_diff   = (hi_tmp_q > cnt_q) ? (hi_tmp_q - cnt_q) : (cnt_q - hi_tmp_q);
`endif

   always_comb begin
      sync1_d  = sig_in;
      sync2_d  = sync1_q;
      dly_d    = sync2_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_tmp_d = hi_tmp_q;
      high_d   = high_q;
      low_d    = low_q;
      period_d = period_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      err_d    = err_q;
      match_d  = match_q;
`ifdef DUTY_CHECK_EN
      duty_d   = duty_q;
`endif
      if (!en) begin
         // Dropping enable abandons any partial measurement and forgets lock history.
         state_d  = IDLE;
         locked_d = 1'b0;
         match_d  = 4'd0;
`ifdef DUTY_CHECK_EN
         duty_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: state_d = WAIT_RISE;
            WAIT_RISE: begin
               if (rise_det) begin
                  cnt_d   = ONE;
                  state_d = MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               if (fall_det) begin
                  hi_tmp_d = cnt_q;
                  cnt_d    = ONE;
                  state_d  = MEAS_LOW;
               end else if (timeout_hit) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = 4'd0;
                  state_d  = WAIT_RISE;
`ifdef DUTY_CHECK_EN
                  duty_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            MEAS_LOW: begin
               if (rise_det) begin
                  high_d   = hi_tmp_q;
                  low_d    = cnt_q;
                  period_d = new_period;
                  valid_d  = 1'b1;
                  err_d    = 1'b0;
                  cnt_d    = ONE;
                  state_d  = MEAS_HIGH;
                  // match_q == 0 marks the first measurement since IDLE or a timeout.
                  if (match_q != 4'd0 && new_period == period_q) begin
                     if (match_q < LOCK_V) match_d = match_q + 4'd1;
                  end else begin
                     match_d = 4'd1;
                  end
                  locked_d = (match_d == LOCK_V);
`ifdef DUTY_CHECK_EN
                  duty_d   = (duty_diff <= ONE);
`endif
               end else if (timeout_hit) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = 4'd0;
                  state_d  = WAIT_RISE;
`ifdef DUTY_CHECK_EN
                  duty_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         dly_q    <= 1'b0;
         cnt_q    <= '0;
         hi_tmp_q <= '0;
         high_q   <= '0;
         low_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         match_q  <= 4'd0;
`ifdef DUTY_CHECK_EN
         duty_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         hi_tmp_q <= hi_tmp_d;
         high_q   <= high_d;
         low_q    <= low_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         match_q  <= match_d;
`ifdef DUTY_CHECK_EN
         duty_q   <= duty_d;
`endif
      end
   end

   assign high_cnt    = high_q;
   assign low_cnt     = low_q;
   assign period      = period_q;
   assign valid       = valid_q;
   assign locked      = locked_q;
   assign err_timeout = err_q;
`ifdef DUTY_CHECK_EN
   assign duty_ok     = duty_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected measurements, a monitor pops them on valid.
module tb_clk_period_meter;
   localparam int CNT_W = 16;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             sig_in;
   logic             en;
   logic [CNT_W-1:0] high_cnt, low_cnt, period;
   logic             valid, locked, err_timeout;
`ifdef DUTY_CHECK_EN
   logic             duty_ok;
`endif

   typedef struct {
      int hi;
      int lo;
      int per;
      bit lk;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors    = 0;
   int   checks    = 0;
   int   valid_cnt = 0;
   int   vcnt_snap = 0;

   clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(64), .LOCK_CNT(4)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .sig_in      (sig_in),
      .en          (en),
      .high_cnt    (high_cnt),
      .low_cnt     (low_cnt),
      .period      (period),
      .valid       (valid),
      .locked      (locked),
`ifdef DUTY_CHECK_EN
      .duty_ok     (duty_ok),
`endif
      .err_timeout (err_timeout)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // n expected measurements of hi/lo cycles; locked from the lock_from-th one on
   task automatic push_n(input int hi, input int lo, input int n, input int lock_from);
      for (int i = 1; i <= n; i++) exp_q.push_back('{hi, lo, hi + lo, (i >= lock_from)});
   endtask

   // n full periods starting with a rise; all edges land 3 time units after a posedge
   task automatic burst(input int hi_t, input int lo_t, input int n);
      repeat (n) begin
         sig_in = 1'b1;
         #(hi_t);
         sig_in = 1'b0;
         #(lo_t);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk_in);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected valids still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_high"}, int'(high_cnt), 0);
      check({tag, "_low"}, int'(low_cnt), 0);
      check({tag, "_period"}, int'(period), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_err"}, int'(err_timeout), 0);
`ifdef DUTY_CHECK_EN
      check({tag, "_duty"}, int'(duty_ok), 0);
`endif
   endtask

   // Monitor: every valid must match the oldest expected measurement.
   always @(negedge clk_in) begin
      if (rst && valid) begin
         valid_cnt++;
         $display("valid %0d: high=%0d low=%0d period=%0d locked=%0b err=%0b",
                  valid_cnt, high_cnt, low_cnt, period, locked, err_timeout);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid with period=%0d, required no valid", period);
         end else begin
            mon_e = exp_q.pop_front();
            check("high_cnt", int'(high_cnt), mon_e.hi);
            check("low_cnt", int'(low_cnt), mon_e.lo);
            check("period", int'(period), mon_e.per);
            check("locked", int'(locked), int'(mon_e.lk));
            check("err_on_valid", int'(err_timeout), 0);
`ifdef DUTY_CHECK_EN
            check("duty_ok", int'(duty_ok), 1);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b0;
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #2;
      check_all_zero("reset");
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(posedge clk_in);
      #3;

      // /4, /15 (7 high, 8 low with these edge offsets), /10, then switch to /12
      push_n(2, 2, 5, 4);
      burst(20, 20, 5);
      push_n(7, 8, 4, 4);
      burst(75, 75, 4);
      push_n(5, 5, 5, 4);
      burst(50, 50, 5);
      push_n(6, 6, 4, 4);
      burst(60, 60, 4);

      // Stuck high: rise detected 27 units later, timeout 64 cycles after that
      sig_in = 1'b1;
      #662;
      check("pre_timeout_err", int'(err_timeout), 0);
      check("pre_timeout_locked", int'(locked), 1);
      #10;
      check("timeout_err", int'(err_timeout), 1);
      check("timeout_locked", int'(locked), 0);
      check("timeout_hold_high", int'(high_cnt), 6);
      check("timeout_hold_period", int'(period), 12);
      check("timeout_valid_count", valid_cnt, 18);

      // Restart at /6; err stays up until the first valid
      @(posedge clk_in);
      #3;
      sig_in = 1'b0;
      #30;
      check("err_held", int'(err_timeout), 1);
      push_n(3, 3, 4, 4);
      burst(30, 30, 4);
      sig_in = 1'b1;
      #30;
      sig_in = 1'b0;

      // Drop en while in the low phase
      #45;
      check("locked_before_drop", int'(locked), 1);
      vcnt_snap = valid_cnt;
      en = 1'b0;
      #5;
      check("drop_locked", int'(locked), 0);
      check("drop_valid", int'(valid), 0);
      check("drop_hold_high", int'(high_cnt), 3);
      check("drop_hold_low", int'(low_cnt), 3);
      check("drop_hold_period", int'(period), 6);
      #20 sig_in = 1'b1;
      #40 sig_in = 1'b0;
      #40;
      check("no_valid_while_disabled", valid_cnt, vcnt_snap);

      @(posedge clk_in);
      #3;
      en = 1'b1;
      #30;
      push_n(3, 3, 2, 99);
      burst(30, 30, 2);
      sig_in = 1'b1;
      wait_drain("en_restart_drain");

      // Async reset while measuring the high phase
      #4;
      rst = 1'b0;
      #2;
      check_all_zero("midrun_reset");
      sig_in = 1'b0;
      #20;
      rst = 1'b1;
      @(posedge clk_in);
      #3;
      #30;
      push_n(3, 3, 2, 99);
      burst(30, 30, 2);
      sig_in = 1'b1;
      wait_drain("post_reset_drain");
      repeat (5) @(posedge clk_in);
      check("total_valids", valid_cnt, 26);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
